// File: rtl/fp_norm_round.sv
// FP32 normalize / round-to-nearest-even / pack stage, two-deep valid/ready pipeline.
// S1 aligns the mantissa using the upstream leading-zero count; S2 rounds and packs.
module fp_norm_round #(
    parameter int MAN_W = 28,
    parameter int EXP_W = 10,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_sign_i,
    input  logic [EXP_W-1:0] in_exp_i,
    input  logic [MAN_W-1:0] in_man_i,
    input  logic [CNT_W-1:0] in_lzc_cnt_i,
    input  logic             in_lzc_empty_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_result_o,
    output logic             out_of_o,
    output logic             out_uf_o,
    output logic             out_nx_o
);
    localparam int XW = EXP_W + 1;
    localparam logic signed [XW-1:0] C_ONE   = XW'(1);
    localparam logic signed [XW-1:0] C_SHMAX = XW'(MAN_W);
    localparam logic signed [XW-1:0] C_EMAX  = XW'(255);

    logic                   r_rdy_en;
    logic                   r_s1_valid;
    logic                   r_s1_sign;
    logic signed [XW-1:0]   r_s1_exp;
    logic [MAN_W-1:0]       r_s1_man;
    logic                   r_s1_zero;
    logic                   r_s2_valid;
    logic [31:0]            r_res;
    logic                   r_of;
    logic                   r_uf;
    logic                   r_nx;

    logic                   w_s2_ready;
    logic                   w_s1_adv;
    logic                   w_s1_load;
    logic signed [XW-1:0]   w_e;
    logic signed [XW-1:0]   w_cm1;
    logic signed [XW-1:0]   w_em1;
    logic signed [XW-1:0]   w_l;
    logic signed [XW-1:0]   w_sh;
    logic                   w_stk;
    logic [MAN_W-1:0]       w_man_n;
    logic signed [XW-1:0]   w_exp_n;

    logic                   w_lsb;
    logic                   w_g;
    logic                   w_s;
    logic                   w_nx;
    logic                   w_rup;
    logic [7:0]             w_exp8;
    logic [30:0]            w_sum;
    logic [31:0]            w_res_n;
    logic                   w_of_n;
    logic                   w_uf_n;
    logic                   w_nx_n;

    // Input and output transfers may coincide: S1 frees up whenever S2 can take its beat.
    assign w_s2_ready  = !r_s2_valid || out_ready_i;
    assign w_s1_adv    = r_s1_valid && w_s2_ready;
    assign in_ready_o  = r_rdy_en && (!r_s1_valid || w_s1_adv);
    assign w_s1_load   = in_valid_i && in_ready_o;

    assign w_e   = {in_exp_i[EXP_W-1], in_exp_i};
    assign w_cm1 = $signed({{(XW-CNT_W){1'b0}}, in_lzc_cnt_i}) - C_ONE;
    assign w_em1 = w_e - C_ONE;

    always_comb begin
        w_man_n = '0;
        w_exp_n = '0;
        w_l     = '0;
        w_sh    = '0;
        w_stk   = 1'b0;
        if (in_lzc_empty_i) begin
            w_man_n = '0;
        end else if (in_lzc_cnt_i == '0) begin
            w_man_n = {1'b0, in_man_i[MAN_W-1:2], in_man_i[1] | in_man_i[0]};
            w_exp_n = w_e + C_ONE;
        end else if (w_e >= C_ONE) begin
            // Left shift is capped so the exponent never drops below 1; a cap that leaves
            // bit26 clear is a denormal.
            w_l     = (w_cm1 < w_em1) ? w_cm1 : w_em1;
            w_man_n = in_man_i << w_l;
            w_exp_n = w_e - w_l;
            if ((w_exp_n == C_ONE) && !w_man_n[MAN_W-2])
                w_exp_n = '0;
        end else begin
            w_sh = C_ONE - w_e;
            if (w_sh > C_SHMAX)
                w_sh = C_SHMAX;
            for (int unsigned i = 0; i < MAN_W; i++) begin
                if (XW'(i) < w_sh)
                    w_stk = w_stk | in_man_i[i];
            end
            w_man_n    = in_man_i >> w_sh;
            w_man_n[0] = w_man_n[0] | w_stk;
            w_exp_n    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdy_en   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_man   <= '0;
            r_s1_zero  <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (flush_i)
                r_s1_valid <= 1'b0;
            else if (w_s1_load)
                r_s1_valid <= 1'b1;
            else if (w_s1_adv)
                r_s1_valid <= 1'b0;
            if (w_s1_load && !flush_i) begin
                r_s1_sign <= in_sign_i;
                r_s1_exp  <= w_exp_n;
                r_s1_man  <= w_man_n;
                r_s1_zero <= in_lzc_empty_i;
            end
        end
    end

    assign w_lsb  = r_s1_man[3];
    assign w_g    = r_s1_man[2];
    assign w_s    = r_s1_man[1] | r_s1_man[0];
    assign w_nx   = w_g | w_s;
    assign w_rup  = w_g & (w_s | w_lsb);
    assign w_exp8 = (r_s1_exp[XW-1] || (r_s1_exp == '0)) ? 8'h00 : r_s1_exp[7:0];
    // The increment ripples from fraction into exponent, covering denormal->normal and ->inf.
    assign w_sum  = {w_exp8, r_s1_man[MAN_W-3:3]} + {30'b0, w_rup};

    always_comb begin
        w_res_n = {r_s1_sign, w_sum};
        w_of_n  = (w_sum[30:23] == 8'hFF);
        w_uf_n  = (w_exp8 == 8'h00) && w_nx;
        w_nx_n  = w_nx;
        if (r_s1_zero) begin
            w_res_n = {r_s1_sign, 31'b0};
            w_of_n  = 1'b0;
            w_uf_n  = 1'b0;
            w_nx_n  = 1'b0;
        end else if (r_s1_exp >= C_EMAX) begin
            w_res_n = {r_s1_sign, 8'hFF, 23'b0};
            w_of_n  = 1'b1;
            w_uf_n  = 1'b0;
            w_nx_n  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_of       <= 1'b0;
            r_uf       <= 1'b0;
            r_nx       <= 1'b0;
        end else begin
            if (flush_i)
                r_s2_valid <= 1'b0;
            else if (w_s2_ready)
                r_s2_valid <= r_s1_valid;
            if (w_s1_adv && !flush_i) begin
                r_res <= w_res_n;
                r_of  <= w_of_n;
                r_uf  <= w_uf_n;
                r_nx  <= w_nx_n;
            end
        end
    end

    assign out_valid_o  = r_s2_valid;
    assign out_result_o = r_res;
    assign out_of_o     = r_of;
    assign out_uf_o     = r_uf;
    assign out_nx_o     = r_nx;
endmodule

// File: tb/tb_fp_norm_round.sv
// Directed-vector bench for fp_norm_round: hand-computed FP32 results, flags, latency,
// backpressure, flush and mid-flight reset.
module tb_fp_norm_round;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_sign_i;
    logic [9:0]  in_exp_i;
    logic [27:0] in_man_i;
    logic [5:0]  in_lzc_cnt_i;
    logic        in_lzc_empty_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_result_o;
    logic        out_of_o;
    logic        out_uf_o;
    logic        out_nx_o;

    int n_checks = 0;
    int n_fail   = 0;

    fp_norm_round #(.MAN_W(28), .EXP_W(10), .CNT_W(6)) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_sign_i      (in_sign_i),
        .in_exp_i       (in_exp_i),
        .in_man_i       (in_man_i),
        .in_lzc_cnt_i   (in_lzc_cnt_i),
        .in_lzc_empty_i (in_lzc_empty_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_result_o   (out_result_o),
        .out_of_o       (out_of_o),
        .out_uf_o       (out_uf_o),
        .out_nx_o       (out_nx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp_v);
        end
    endtask

    task automatic drive(input logic sg, input logic [9:0] ex, input logic [27:0] mn,
                         input logic [5:0] ct, input logic em);
        in_sign_i      = sg;
        in_exp_i       = ex;
        in_man_i       = mn;
        in_lzc_cnt_i   = ct;
        in_lzc_empty_i = em;
    endtask

    // One beat through an idle pipeline; flags are packed {of, uf, nx}.
    task automatic send_vec(input string tag, input logic sg, input logic [9:0] ex,
                            input logic [27:0] mn, input logic [5:0] ct, input logic em,
                            input logic [31:0] er, input logic [2:0] efl);
        int k;
        drive(sg, ex, mn, ct, em);
        in_valid_i = 1'b1;
        k = 0;
        while (!in_ready_o && k < 20) begin
            @(posedge clk_i); #1;
            k++;
        end
        chk({tag, "_inrdy"}, 32'(in_ready_o), 32'd1);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid_o), 32'd0);
        @(posedge clk_i); #1;
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        chk({tag, "_res"}, out_result_o, er);
        chk({tag, "_flags"}, 32'({out_of_o, out_uf_o, out_nx_o}), 32'(efl));
        @(posedge clk_i); #1;
    endtask

    initial begin
        logic seen;
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b0, 10'd0, 28'h0, 6'd0, 1'b0);
        #3;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_inrdy", 32'(in_ready_o), 32'd0);
        chk("rst_res", out_result_o, 32'd0);
        chk("rst_flags", 32'({out_of_o, out_uf_o, out_nx_o}), 32'd0);
        #20 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_inrdy", 32'(in_ready_o), 32'd1);

        send_vec("unity",     1'b0, 10'd127,  28'h4000000, 6'd1, 1'b0, 32'h3F800000, 3'b000);
        send_vec("carry_tie", 1'b0, 10'd127,  28'h8000008, 6'd0, 1'b0, 32'h40000000, 3'b001);
        send_vec("rnd_carry", 1'b0, 10'd127,  28'h7FFFFFC, 6'd1, 1'b0, 32'h40000000, 3'b001);
        send_vec("den_clamp", 1'b0, 10'd1,    28'h0100000, 6'd7, 1'b0, 32'h00020000, 3'b000);
        send_vec("den_inex",  1'b0, 10'd1,    28'h0100001, 6'd7, 1'b0, 32'h00020000, 3'b011);
        send_vec("ovf",       1'b0, 10'd300,  28'h4000000, 6'd1, 1'b0, 32'h7F800000, 3'b101);
        send_vec("negzero",   1'b1, 10'd0,    28'h0000000, 6'd28, 1'b1, 32'h80000000, 3'b000);
        send_vec("lnorm",     1'b0, 10'd127,  28'h0100000, 6'd7, 1'b0, 32'h3C800000, 3'b000);
        send_vec("rsh1",      1'b0, 10'd0,    28'h4000000, 6'd1, 1'b0, 32'h00400000, 3'b000);
        send_vec("rsh2_stk",  1'b0, 10'h3FF,  28'h4000006, 6'd1, 1'b0, 32'h00200000, 3'b011);
        send_vec("rsh_sat",   1'b0, 10'h39C,  28'h4000000, 6'd1, 1'b0, 32'h00000000, 3'b011);
        send_vec("rnd_inf",   1'b0, 10'd254,  28'h7FFFFFC, 6'd1, 1'b0, 32'h7F800000, 3'b101);
        send_vec("tie_odd",   1'b0, 10'd127,  28'h400000C, 6'd1, 1'b0, 32'h3F800002, 3'b001);
        send_vec("neg_two",   1'b1, 10'd128,  28'h4000000, 6'd1, 1'b0, 32'hC0000000, 3'b000);

        // Backpressure: two beats fill the pipe, the third is refused, output holds.
        out_ready_i = 1'b0;
        drive(1'b0, 10'd127, 28'h4000000, 6'd1, 1'b0);
        in_valid_i = 1'b1;
        chk("stall_rdyA", 32'(in_ready_o), 32'd1);
        @(posedge clk_i); #1;
        drive(1'b0, 10'd127, 28'h400000C, 6'd1, 1'b0);
        chk("stall_rdyB", 32'(in_ready_o), 32'd1);
        @(posedge clk_i); #1;
        drive(1'b0, 10'd200, 28'h4000000, 6'd1, 1'b0);
        chk("stall_rdyC", 32'(in_ready_o), 32'd0);
        chk("stall_validA", 32'(out_valid_o), 32'd1);
        chk("stall_resA", out_result_o, 32'h3F800000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i); #1;
            chk("stall_hold_rdy", 32'(in_ready_o), 32'd0);
            chk("stall_hold_res", out_result_o, 32'h3F800000);
            chk("stall_hold_flags", 32'({out_of_o, out_uf_o, out_nx_o}), 32'd0);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("drain_validB", 32'(out_valid_o), 32'd1);
        chk("drain_resB", out_result_o, 32'h3F800002);
        chk("drain_flagsB", 32'({out_of_o, out_uf_o, out_nx_o}), 32'd1);
        @(posedge clk_i); #1;
        chk("drain_empty", 32'(out_valid_o), 32'd0);

        // Flush with a beat in S1 and another presented in the same cycle.
        drive(1'b0, 10'd127, 28'h4000000, 6'd1, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        drive(1'b0, 10'd128, 28'h4000000, 6'd1, 1'b0);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_valid", 32'(out_valid_o), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            seen = seen | out_valid_o;
        end
        chk("flush_drop", 32'(seen), 32'd0);
        send_vec("post_flush", 1'b0, 10'd128, 28'h4000000, 6'd1, 1'b0, 32'h40000000, 3'b000);

        // Asynchronous reset with a beat in flight.
        drive(1'b0, 10'd127, 28'h4000000, 6'd1, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid_o), 32'd0);
        chk("mrst_inrdy", 32'(in_ready_o), 32'd0);
        chk("mrst_res", out_result_o, 32'd0);
        #2 rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            seen = seen | out_valid_o;
        end
        chk("mrst_drop", 32'(seen), 32'd0);
        send_vec("post_rst", 1'b1, 10'd127, 28'h8000008, 6'd0, 1'b0, 32'hC0000000, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
